// File: rtl/dw_conv_feeder_if.sv
// dw_conv_feeder_if: upstream pixel stream plus the push bus into the pre-process stage.
interface dw_conv_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_CHANNEL_NUM = 18
);
    logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0] s_data;
    logic s_valid;
    logic s_ready;
    logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0] data_out;
    logic valid_out;
    logic win_valid;
    modport slave (input s_data, s_valid, output s_ready, data_out, valid_out, win_valid);
    modport master (output s_data, s_valid, input s_ready, data_out, valid_out, win_valid);
endinterface

// File: rtl/dw_conv_feeder.sv
// dw_conv_feeder: schedules one padded frame into the depthwise-conv row buffer and window generator.
module dw_conv_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_CHANNEL_NUM = 18,
    parameter int MAX_WIDTH = 320,
    parameter int MAX_HEIGHT = 320,
    parameter int DEPTH = $clog2(MAX_WIDTH + 1),
    parameter int HDEPTH = $clog2(MAX_HEIGHT + 1)
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic [DEPTH-1:0] cfg_width,
    input  logic [HDEPTH-1:0] cfg_height,
    input  logic cfg_pad,
    dw_conv_feeder_if.slave bus,
    output logic [DEPTH-1:0] buff_len_ctrl,
    output logic buff_len_rst,
    output logic busy,
    output logic done,
    output logic cfg_err
);
    typedef enum logic [1:0] {IDLE, RSTBUF, STREAM, FIN} state_t;
    localparam logic [DEPTH:0] C1 = 1;
    localparam logic [DEPTH:0] C2 = 2;
    localparam logic [HDEPTH:0] R1 = 1;
    localparam logic [HDEPTH:0] R2 = 2;
    state_t state, state_nx;
    logic p, pad_slot, ready, fire, last, accept, legal;
    logic [DEPTH:0] c, pw_m1;
    logic [HDEPTH:0] r, ph_m1;
    logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0] data_q;
    logic valid_q, win_q;
    assign legal = cfg_width >= DEPTH'(3) && cfg_width <= DEPTH'(MAX_WIDTH)
                && cfg_height >= HDEPTH'(3) && cfg_height <= HDEPTH'(MAX_HEIGHT);
    assign accept = state == IDLE && start && legal;
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else state <= state_nx;
    end
    // ready depends only on state and position so upstream never sees a combinational loop
    always_comb begin
        state_nx = state;
        pad_slot = p && (r == '0 || r == ph_m1 || c == '0 || c == pw_m1);
        ready = state == STREAM && !pad_slot;
        fire = state == STREAM && (pad_slot || bus.s_valid);
        last = r == ph_m1 && c == pw_m1;
        case (state)
            IDLE:   state_nx = accept ? RSTBUF : IDLE;
            RSTBUF: state_nx = STREAM;
            STREAM: state_nx = fire && last ? FIN : STREAM;
            FIN:    state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            p <= 1'b0;
            r <= '0;
            c <= '0;
            pw_m1 <= '0;
            ph_m1 <= '0;
            data_q <= '0;
            valid_q <= 1'b0;
            win_q <= 1'b0;
            buff_len_ctrl <= '0;
            buff_len_rst <= 1'b0;
            done <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            buff_len_rst <= accept;
            cfg_err <= state == IDLE && start && !legal;
            valid_q <= fire;
            win_q <= fire && r >= R2 && c >= C2;
            done <= fire && last;
            if (fire) data_q <= pad_slot ? '0 : bus.s_data;
            if (accept) begin
                p <= cfg_pad;
                pw_m1 <= cfg_pad ? {1'b0, cfg_width} + C1 : {1'b0, cfg_width} - C1;
                ph_m1 <= cfg_pad ? {1'b0, cfg_height} + R1 : {1'b0, cfg_height} - R1;
                buff_len_ctrl <= cfg_pad ? cfg_width : cfg_width - DEPTH'(2);
                r <= '0;
                c <= '0;
            end else if (fire) begin
                c <= c == pw_m1 ? '0 : c + C1;
                r <= c == pw_m1 ? r + R1 : r;
            end
        end
    end
    assign busy = state != IDLE;
    assign bus.s_ready = ready;
    assign bus.data_out = data_q;
    assign bus.valid_out = valid_q;
    assign bus.win_valid = win_q;
endmodule
